seq_signed_divider: RTL and testbench

Multi-cycle signed restoring divider that performs the inverse of the 5-bit modified-Booth multiplier. It divides a 10-bit signed dividend (the multiplier's product width) by a 5-bit signed divisor (the multiplier's operand width) and returns a 5-bit signed quotient and remainder. It uses the same single-cycle `in_valid`/`out_valid` pulse handshake, so the two blocks can be chained for multiply/divide round-trip checking in the arithmetic datapath.

---
 rtl/arith_pkg.sv | 18 +
 rtl/div_restore_step.sv | 40 ++++
 rtl/seq_signed_divider.sv | 202 ++++++++++++++++++++
 tb/tb_seq_signed_divider.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions for the Booth multiplier / restoring
// divider pair: operand width, divider FSM states and fixed divider latency.
package arith_pkg;

    // Operand width; the dividend / product is 2*N bits wide.
    localparam int unsigned N = 5;

    // Cycles from request accept to out_valid: 2N restoring steps + DONE.
    localparam int unsigned DIV_LATENCY = 2 * N + 1;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step (combinational).
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor magnitude when it fits.
//   rem_i      partial remainder before the step (W+1 bits)
//   bit_i      next dividend bit, MSB first
//   divisor_i  divisor magnitude |B| (W bits)
//   rem_o      partial remainder after the step
//   q_bit_o    quotient bit produced by this step
module div_restore_step #(
    parameter int unsigned W = 5
) (
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W:0]   rem_o,
    output logic         q_bit_o
);

    localparam int unsigned RW = W + 1;
    localparam int unsigned SW = W + 2;

    // The shifted value is kept one bit wider than the remainder so the
    // compare never loses the bit shifted out of the top.
    logic [SW-1:0] shifted_c;
    logic [SW-1:0] divisor_ext_c;

    assign shifted_c     = {rem_i, bit_i};
    assign divisor_ext_c = {2'b00, divisor_i};

    // Trial subtraction; keep the difference only when it does not go negative.
    always_comb begin
        q_bit_o = 1'b0;
        rem_o   = RW'(shifted_c);
        if (shifted_c >= divisor_ext_c) begin
            q_bit_o = 1'b1;
            rem_o   = RW'(shifted_c - divisor_ext_c);
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed restoring divider: 2N-bit signed dividend by N-bit signed
// divisor, N-bit signed quotient (truncated toward zero) and remainder (sign
// of the dividend). Fixed latency of 2N+1 cycles from accept to out_valid.
//   clock      rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request strobe, sampled while in_ready is high
//   A_in       signed dividend (2N bits)
//   B_in       signed divisor (N bits)
//   in_ready   high while idle
//   Q_out      signed quotient, saturated on overflow
//   R_out      signed remainder
//   out_valid  one-cycle result strobe
//   div_zero   divisor was zero (valid with out_valid)
//   overflow   true quotient outside the N-bit signed range (valid with out_valid)
module seq_signed_divider #(
    parameter int unsigned N = arith_pkg::N
) (
    input  logic           clock,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [2*N-1:0] A_in,
    input  logic [N-1:0]   B_in,
    output logic           in_ready,
    output logic [N-1:0]   Q_out,
    output logic [N-1:0]   R_out,
    output logic           out_valid,
    output logic           div_zero,
    output logic           overflow
);

    import arith_pkg::*;

    localparam int unsigned AW = 2 * N;
    localparam int unsigned RW = N + 1;
    localparam int unsigned CW = $clog2(AW + 1);

    // Largest quotient magnitudes representable for each result sign.
    localparam logic [AW-1:0] Q_POS_MAX = AW'((1 << (N - 1)) - 1);
    localparam logic [AW-1:0] Q_NEG_MAX = AW'(1 << (N - 1));
    localparam logic [N-1:0]  Q_SAT_POS = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0]  Q_SAT_NEG = {1'b1, {(N - 1){1'b0}}};

    div_state_e     state_q,     state_d;
    logic [AW-1:0]  a_mag_q,     a_mag_d;
    logic [N-1:0]   b_mag_q,     b_mag_d;
    logic [RW-1:0]  rem_q,       rem_d;
    logic [AW-1:0]  quo_q,       quo_d;
    logic [CW-1:0]  cnt_q,       cnt_d;
    logic           q_neg_q,     q_neg_d;
    logic           r_neg_q,     r_neg_d;
    logic           zflag_q,     zflag_d;

    logic           in_ready_q,  in_ready_d;
    logic [N-1:0]   q_out_q,     q_out_d;
    logic [N-1:0]   r_out_q,     r_out_d;
    logic           out_valid_q, out_valid_d;
    logic           div_zero_q,  div_zero_d;
    logic           overflow_q,  overflow_d;

    logic [AW-1:0]  a_abs_c;
    logic [N-1:0]   b_abs_c;
    logic [RW-1:0]  step_rem_c;
    logic           step_qbit_c;

    // Magnitudes of the request operands; the most negative values map to
    // their unsigned magnitude (e.g. -512 -> 512) and still fit.
    assign a_abs_c = A_in[AW-1] ? AW'(-A_in) : A_in;
    assign b_abs_c = B_in[N-1]  ? N'(-B_in)  : B_in;

    // Single restoring step on the current partial remainder.
    div_restore_step #(
        .W (N)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (a_mag_q[AW-1]),
        .divisor_i (b_mag_q),
        .rem_o     (step_rem_c),
        .q_bit_o   (step_qbit_c)
    );

    // State and datapath registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            zflag_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            q_out_q     <= '0;
            r_out_q     <= '0;
            out_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_mag_q     <= a_mag_d;
            b_mag_q     <= b_mag_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            zflag_q     <= zflag_d;
            in_ready_q  <= in_ready_d;
            q_out_q     <= q_out_d;
            r_out_q     <= r_out_d;
            out_valid_q <= out_valid_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state, datapath update and result formatting.
    always_comb begin
        state_d     = state_q;
        a_mag_d     = a_mag_q;
        b_mag_d     = b_mag_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        zflag_d     = zflag_q;
        q_out_d     = q_out_q;
        r_out_d     = r_out_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_mag_d = a_abs_c;
                    b_mag_d = b_abs_c;
                    q_neg_d = A_in[AW-1] ^ B_in[N-1];
                    r_neg_d = A_in[AW-1];
                    zflag_d = (B_in == '0);
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end

            // Runs the full 2N steps even for a zero divisor so latency is fixed.
            DIV: begin
                rem_d   = step_rem_c;
                quo_d   = {quo_q[AW-2:0], step_qbit_c};
                a_mag_d = {a_mag_q[AW-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(AW - 1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                out_valid_d = 1'b1;
                state_d     = IDLE;
                if (zflag_q) begin
                    div_zero_d = 1'b1;
                    overflow_d = 1'b0;
                    q_out_d    = '0;
                    r_out_d    = '0;
                end else begin
                    div_zero_d = 1'b0;
                    // |r| < |B| <= 2^(N-1), so the remainder always fits in N bits.
                    r_out_d = r_neg_q ? N'(-rem_q[N-1:0]) : rem_q[N-1:0];
                    if (!q_neg_q && (quo_q > Q_POS_MAX)) begin
                        overflow_d = 1'b1;
                        q_out_d    = Q_SAT_POS;
                    end else if (q_neg_q && (quo_q > Q_NEG_MAX)) begin
                        overflow_d = 1'b1;
                        q_out_d    = Q_SAT_NEG;
                    end else begin
                        overflow_d = 1'b0;
                        q_out_d    = q_neg_q ? N'(-quo_q[N-1:0]) : quo_q[N-1:0];
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered ready so it is already high in the out_valid cycle.
        in_ready_d = (state_d == IDLE);
    end

    assign in_ready  = in_ready_q;
    assign Q_out     = q_out_q;
    assign R_out     = r_out_q;
    assign out_valid = out_valid_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed self-checking bench for seq_signed_divider (N = 5).
module tb_seq_signed_divider;

    logic       clock;
    logic       rst;
    logic       in_valid;
    logic [9:0] A_in;
    logic [4:0] B_in;
    logic       in_ready;
    logic [4:0] Q_out;
    logic [4:0] R_out;
    logic       out_valid;
    logic       div_zero;
    logic       overflow;

    int n_checks;
    int n_fail;

    seq_signed_divider #(.N(5)) dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .A_in      (A_in),
        .B_in      (B_in),
        .in_ready  (in_ready),
        .Q_out     (Q_out),
        .R_out     (R_out),
        .out_valid (out_valid),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request before a rising edge; returns #1 after the accept edge.
    task automatic start_req(input logic [9:0] a, input logic [4:0] b);
        @(negedge clock);
        A_in     = a;
        B_in     = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after accept until out_valid is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!out_valid && lat < 30);
    endtask

    task automatic check_result(input string tag, input int lat,
                                input logic [4:0] exp_q, input logic [4:0] exp_r,
                                input logic exp_dz, input logic exp_ov);
        check_eq({tag, "_lat"}, 32'(lat), 32'd11);
        check_eq({tag, "_q"},   32'(Q_out), 32'(exp_q));
        check_eq({tag, "_r"},   32'(R_out), 32'(exp_r));
        check_eq({tag, "_dz"},  32'(div_zero), 32'(exp_dz));
        check_eq({tag, "_ov"},  32'(overflow), 32'(exp_ov));
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_div(input string tag, input logic [9:0] a, input logic [4:0] b,
                           input logic [4:0] exp_q, input logic [4:0] exp_r,
                           input logic exp_dz, input logic exp_ov);
        int lat;
        start_req(a, b);
        check_eq({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_done(lat);
        check_result(tag, lat, exp_q, exp_r, exp_dz, exp_ov);
        @(posedge clock);
        #1;
        check_eq({tag, "_pulse"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_hold"},  32'(Q_out), 32'(exp_q));
    endtask

    initial begin
        int lat;
        int pulses;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        A_in     = '0;
        B_in     = '0;

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_rdy", 32'(in_ready),  32'd1);
        check_eq("rst_q",   32'(Q_out),     32'd0);
        check_eq("rst_r",   32'(R_out),     32'd0);
        check_eq("rst_ov",  32'(out_valid), 32'd0);
        check_eq("rst_dz",  32'(div_zero),  32'd0);
        check_eq("rst_ovf", 32'(overflow),  32'd0);
        @(negedge clock);
        rst = 1'b0;

        // 24 / -6 = -4 r 0
        run_div("d24_m6",   10'd24,  5'b11010, 5'b11100, 5'b00000, 1'b0, 1'b0);
        // -25 / 4 = -6 r -1
        run_div("dm25_4",   10'h3E7, 5'b00100, 5'b11010, 5'b11111, 1'b0, 1'b0);
        // 100 / 3 = 33 r 1 -> saturate to +15
        run_div("d100_3",   10'd100, 5'b00011, 5'b01111, 5'b00001, 1'b0, 1'b1);
        // -512 / -16 = 32 -> saturate to +15
        run_div("dm512_m16",10'h200, 5'b10000, 5'b01111, 5'b00000, 1'b0, 1'b1);
        // -240 / 15 = -16 exactly, in range
        run_div("dm240_15", 10'h310, 5'b01111, 5'b10000, 5'b00000, 1'b0, 1'b0);
        // 37 / 0 -> divide by zero
        run_div("d37_0",    10'd37,  5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);

        // in_valid during DIV is ignored: 50 / 7 = 7 r 1
        start_req(10'd50, 5'd7);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("ign_busy", 32'(in_ready), 32'd0);
        A_in     = 10'd1;
        B_in     = 5'd1;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        pulses = 0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check_eq("ign_q", 32'(Q_out), 32'd7);
        check_eq("ign_r", 32'(R_out), 32'd1);
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) pulses++;
        end
        check_eq("ign_extra", 32'(pulses), 32'd0);

        // Back-to-back: second request issued in the out_valid cycle.
        start_req(10'd24, 5'b11010);
        wait_done(lat);
        check_result("b2b_first", lat, 5'b11100, 5'b00000, 1'b0, 1'b0);
        A_in     = 10'h3F9;   // -7
        B_in     = 5'd2;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check_eq("b2b_acc", 32'(in_ready), 32'd0);
        wait_done(lat);
        // -7 / 2 = -3 r -1
        check_result("b2b_second", lat, 5'b11101, 5'b11111, 1'b0, 1'b0);

        // Reset in the middle of DIV discards the operation.
        start_req(10'd100, 5'd7);
        repeat (5) @(posedge clock);
        #1;
        rst = 1'b1;
        #2;
        check_eq("mid_rst_rdy", 32'(in_ready),  32'd1);
        check_eq("mid_rst_q",   32'(Q_out),     32'd0);
        check_eq("mid_rst_r",   32'(R_out),     32'd0);
        check_eq("mid_rst_ov",  32'(out_valid), 32'd0);
        @(negedge clock);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) pulses++;
        end
        check_eq("mid_rst_nopulse", 32'(pulses), 32'd0);

        // Block still operates after the aborted operation: 100 / 7 = 14 r 2
        run_div("post_rst", 10'd100, 5'd7, 5'd14, 5'd2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
